// File: rtl/instr_writer_pkg.sv
// Shared constants for the instruction writer: opcodes, request kinds, funct codes, FSM states.
package instr_writer_pkg;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] KIND_LW    = 2'b00;
  localparam logic [1:0] KIND_SW    = 2'b01;
  localparam logic [1:0] KIND_RTYPE = 2'b10;
  localparam logic [1:0] KIND_BEQ   = 2'b11;

  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  // R-type funct is {funct7[5], funct3}
  localparam logic [3:0] FUNCT_ADD = 4'b0000;
  localparam logic [3:0] FUNCT_SUB = 4'b1000;
  localparam logic [3:0] FUNCT_SLT = 4'b0010;
  localparam logic [3:0] FUNCT_OR  = 4'b0110;
  localparam logic [3:0] FUNCT_AND = 4'b0111;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  function automatic logic funct_supported(input logic [3:0] f);
    return (f == FUNCT_ADD) || (f == FUNCT_SUB) || (f == FUNCT_SLT) ||
           (f == FUNCT_OR)  || (f == FUNCT_AND);
  endfunction

endpackage

// File: rtl/instr_writer_if.sv
// Request handshake and instruction-memory write bus of the instruction writer.
interface instr_writer_if #(parameter int ADDR_W = 6);
  logic              clear;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_kind;
  logic [3:0]        req_funct;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [11:0]       req_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  modport master (
    output clear, req_valid, req_kind, req_funct, req_rd, req_rs1, req_rs2, req_imm,
    input  req_ready, mem_we, mem_addr, mem_wdata, count, full, err
  );

  modport slave (
    input  clear, req_valid, req_kind, req_funct, req_rd, req_rs1, req_rs2, req_imm,
    output req_ready, mem_we, mem_addr, mem_wdata, count, full, err
  );
endinterface

// File: rtl/instr_writer_encode.sv
// Combinational assembly of lw/sw/R-type/beq fields into the 32-bit instruction word.
module instr_encode
  import instr_writer_pkg::*;
(
  input  logic [1:0]  kind_i,
  input  logic [3:0]  funct_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [11:0] imm_i,
  output logic [31:0] word_o
);
  always_comb begin
    word_o = '0;
    case (kind_i)
      KIND_LW:    word_o = {imm_i, rs1_i, F3_LW, rd_i, OP_LW};
      KIND_SW:    word_o = {imm_i[11:5], rs2_i, rs1_i, F3_SW, imm_i[4:0], OP_SW};
      KIND_RTYPE: word_o = {1'b0, funct_i[3], 5'b00000, rs2_i, rs1_i, funct_i[2:0], rd_i, OP_RTYPE};
      // imm holds branch offset[12:1], so imm[11] is offset[12]
      default:    word_o = {imm_i[11], imm_i[9:4], rs2_i, rs1_i, F3_BEQ, imm_i[3:0], imm_i[10], OP_BEQ};
    endcase
  end
endmodule

// File: rtl/instr_writer.sv
// Program loader: accepts instruction requests, encodes them and writes consecutive imem words.
// Optional R-type funct legality check under INSTR_WRITER_CHECK_EN.
module instr_writer
  import instr_writer_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input logic          clk,
  input logic          reset,
  instr_writer_if.slave bus
);
  localparam logic [ADDR_W:0]   CAP    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              bad_q, bad_d;
  logic [31:0]       enc_word;
  logic              accept, in_write, bad_req;

  instr_encode u_enc (
    .kind_i (bus.req_kind),
    .funct_i(bus.req_funct),
    .rd_i   (bus.req_rd),
    .rs1_i  (bus.req_rs1),
    .rs2_i  (bus.req_rs2),
    .imm_i  (bus.req_imm),
    .word_o (enc_word)
  );

  assign in_write = (state_q == S_WRITE);
  assign accept   = bus.req_valid & bus.req_ready;

`ifdef INSTR_WRITER_CHECK_EN
  assign bad_req  = (bus.req_kind == KIND_RTYPE) && !funct_supported(bus.req_funct);
  assign bus.err  = in_write & bad_q & ~bus.clear;
`else
  assign bad_req  = 1'b0;
  assign bus.err  = 1'b0;
`endif

  // clear outranks the handshake, so no accept is offered while it is high
  assign bus.req_ready = (state_q == S_IDLE) & ~reset & ~bus.clear;
  assign bus.mem_we    = in_write & ~bad_q & ~bus.clear;
  assign bus.mem_addr  = ptr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.count     = count_q;
  assign bus.full      = (state_q == S_FULL);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    bad_d   = bad_q;
    if (bus.clear) begin
      state_d = S_IDLE;
      ptr_d   = BASE_A;
      count_d = '0;
      bad_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          state_d = S_WRITE;
          bad_d   = bad_req;
          wdata_d = bad_req ? wdata_q : enc_word;
        end
        S_WRITE: begin
          state_d = S_IDLE;
          bad_d   = 1'b0;
          if (!bad_q) begin
            ptr_d   = ptr_q + 1'b1;
            count_d = count_q + 1'b1;
            if (count_q + 1'b1 == CAP) state_d = S_FULL;
          end
        end
        S_FULL:  state_d = S_FULL;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= BASE_A;
      count_q <= '0;
      wdata_q <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      bad_q   <= bad_d;
    end
  end
endmodule

// File: tb/tb_instr_writer.sv
// Self-checking bench for instr_writer with a small capacity (ADDR_W=2) and a field-level reference model.
module tb_instr_writer;
  localparam int AW  = 2;
  localparam int CAP = 1 << AW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   m_ptr = 0;
  int   m_cnt = 0;

  instr_writer_if #(.ADDR_W(AW)) bus ();
  instr_writer #(.ADDR_W(AW), .BASE_ADDR(0)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Reference encoder built from the immediate's byte-offset meaning and field bit positions
  function automatic logic [31:0] ref_word(input int unsigned k, f, rd, rs1, rs2, imm);
    int unsigned off;
    case (k)
      0: return (imm << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 3;
      1: return ((imm >> 5) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12) | ((imm & 31) << 7) | 35;
      2: return (((f >> 3) & 1) << 30) | (rs2 << 20) | (rs1 << 15) | ((f & 7) << 12) | (rd << 7) | 51;
      default: begin
        off = imm * 2;
        return (((off >> 12) & 1) << 31) | (((off >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
             | (((off >> 1) & 15) << 8) | (((off >> 11) & 1) << 7) | 99;
      end
    endcase
  endfunction

  function automatic bit ref_legal(input int unsigned k, f);
`ifdef INSTR_WRITER_CHECK_EN
    int unsigned ok_list[5] = '{0, 8, 2, 6, 7};
    if (k != 2) return 1'b1;
    foreach (ok_list[i]) if (ok_list[i] == f) return 1'b1;
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic drive_idle();
    bus.clear = 0; bus.req_valid = 0; bus.req_kind = 0; bus.req_funct = 0;
    bus.req_rd = 0; bus.req_rs1 = 0; bus.req_rs2 = 0; bus.req_imm = 0;
  endtask

  task automatic do_clear();
    @(negedge clk); bus.clear = 1;
    @(negedge clk); bus.clear = 0;
    m_ptr = 0; m_cnt = 0;
    checks++;
    if (bus.count !== 0) begin errors++; $display("FAIL clear_count got=%0d exp=0", bus.count); end
  endtask

  // Issue one request, check the write cycle and the following cycle against the model
  task automatic send(input logic [1:0] k, input logic [3:0] f, input logic [4:0] rd, rs1, rs2,
                      input logic [11:0] imm, output logic [31:0] seen);
    logic [31:0] exp_w;
    bit legal;
    seen = 'x;
    exp_w = ref_word(k, f, rd, rs1, rs2, imm);
    legal = ref_legal(k, f);
    @(negedge clk);
    bus.req_kind = k; bus.req_funct = f; bus.req_rd = rd; bus.req_rs1 = rs1;
    bus.req_rs2 = rs2; bus.req_imm = imm; bus.req_valid = 1;
    for (int t = 0; t < 20 && !bus.req_ready; t++) @(negedge clk);
    checks++;
    if (!bus.req_ready) begin
      errors++; $display("FAIL accept_timeout got ready=0 exp ready=1");
      bus.req_valid = 0;
      return;
    end
    @(negedge clk);
    bus.req_valid = 0;
    seen = bus.mem_wdata;
    checks += 3;
    if (legal) begin
      if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL write_we got=%b exp=1", bus.mem_we); end
      if (bus.mem_addr !== AW'(m_ptr)) begin errors++; $display("FAIL write_addr got=%0d exp=%0d", bus.mem_addr, m_ptr); end
      if (bus.mem_wdata !== exp_w) begin errors++; $display("FAIL write_data got=%h exp=%h", bus.mem_wdata, exp_w); end
      m_ptr = (m_ptr + 1) % CAP;
      m_cnt++;
    end else begin
      if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reject_we got=%b exp=0", bus.mem_we); end
      if (bus.err !== 1'b1) begin errors++; $display("FAIL reject_err got=%b exp=1", bus.err); end
      if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reject_ready got=%b exp=0", bus.req_ready); end
    end
    @(negedge clk);
    checks += 4;
    if (bus.count !== (AW+1)'(m_cnt)) begin errors++; $display("FAIL count got=%0d exp=%0d", bus.count, m_cnt); end
    if (bus.full !== (m_cnt == CAP)) begin errors++; $display("FAIL full got=%b exp=%b", bus.full, m_cnt == CAP); end
    if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL we_after got=%b exp=0", bus.mem_we); end
    if (bus.err !== 1'b0) begin errors++; $display("FAIL err_after got=%b exp=0", bus.err); end
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1;
    repeat (2) @(negedge clk);
    checks += 7;
    if (bus.req_ready !== 0) begin errors++; $display("FAIL rst_ready got=%b exp=0", bus.req_ready); end
    if (bus.mem_we !== 0) begin errors++; $display("FAIL rst_we got=%b exp=0", bus.mem_we); end
    if (bus.mem_addr !== 0) begin errors++; $display("FAIL rst_addr got=%0d exp=0", bus.mem_addr); end
    if (bus.mem_wdata !== 0) begin errors++; $display("FAIL rst_wdata got=%h exp=0", bus.mem_wdata); end
    if (bus.count !== 0) begin errors++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
    if (bus.full !== 0) begin errors++; $display("FAIL rst_full got=%b exp=0", bus.full); end
    if (bus.err !== 0) begin errors++; $display("FAIL rst_err got=%b exp=0", bus.err); end
    reset = 0;
    m_ptr = 0; m_cnt = 0;
    #1;
    checks++;
    if (bus.req_ready !== 1) begin errors++; $display("FAIL rel_ready got=%b exp=1", bus.req_ready); end
  endtask

  task automatic test_directed();
    logic [31:0] w;
    send(2'b00, 4'h0, 5'd5, 5'd2, 5'd0, 12'd8, w);
    checks++; if (w !== 32'h00812283) begin errors++; $display("FAIL lw_word got=%h exp=00812283", w); end
    do_clear();
    send(2'b01, 4'h0, 5'd0, 5'd3, 5'd6, 12'd4, w);
    checks++; if (w !== 32'h0061A223) begin errors++; $display("FAIL sw_word got=%h exp=0061A223", w); end
    send(2'b10, 4'h0, 5'd1, 5'd2, 5'd3, 12'd0, w);
    checks++; if (w !== 32'h003100B3) begin errors++; $display("FAIL add_word got=%h exp=003100B3", w); end
    send(2'b10, 4'h8, 5'd1, 5'd2, 5'd3, 12'd0, w);
    checks++; if (w !== 32'h403100B3) begin errors++; $display("FAIL sub_word got=%h exp=403100B3", w); end
    send(2'b11, 4'h0, 5'd0, 5'd1, 5'd2, 12'hFFE, w);
    checks++; if (w !== 32'hFE208EE3) begin errors++; $display("FAIL beq_word got=%h exp=FE208EE3", w); end
    checks += 2;
    if (bus.full !== 1) begin errors++; $display("FAIL dir_full got=%b exp=1", bus.full); end
    if (bus.req_ready !== 0) begin errors++; $display("FAIL dir_full_ready got=%b exp=0", bus.req_ready); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    bit exp_we;
    do_clear();
    @(negedge clk);
    bus.req_kind = 2'b10; bus.req_funct = 4'h7; bus.req_rd = 5'd9;
    bus.req_rs1 = 5'd10; bus.req_rs2 = 5'd11; bus.req_valid = 1;
    for (int i = 0; i < 12; i++) begin
      exp_we = (i % 2 == 1) && (i <= 2 * CAP - 1);
      checks++;
      if (bus.mem_we !== exp_we) begin errors++; $display("FAIL b2b_we cyc=%0d got=%b exp=%b", i, bus.mem_we, exp_we); end
      if (exp_we) begin
        checks++;
        if (bus.mem_addr !== AW'((i - 1) / 2)) begin errors++; $display("FAIL b2b_addr cyc=%0d got=%0d exp=%0d", i, bus.mem_addr, (i - 1) / 2); end
      end
      @(negedge clk);
    end
    checks += 3;
    if (bus.count !== CAP) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", bus.count, CAP); end
    if (bus.full !== 1) begin errors++; $display("FAIL b2b_full got=%b exp=1", bus.full); end
    if (bus.req_ready !== 0) begin errors++; $display("FAIL b2b_ready got=%b exp=0", bus.req_ready); end
    bus.req_valid = 0;
    do_clear();
    send(2'b00, 4'h0, 5'd7, 5'd8, 5'd0, 12'h123, w);
    checks++; if (bus.count !== 1) begin errors++; $display("FAIL b2b_clear_count got=%0d exp=1", bus.count); end
  endtask

  task automatic test_clear_in_write();
    do_clear();
    @(negedge clk);
    bus.req_kind = 2'b00; bus.req_rd = 5'd4; bus.req_rs1 = 5'd4; bus.req_imm = 12'h10; bus.req_valid = 1;
    for (int t = 0; t < 20 && !bus.req_ready; t++) @(negedge clk);
    @(negedge clk);
    bus.req_valid = 0;
    bus.clear = 1;
    #1;
    checks++;
    if (bus.mem_we !== 0) begin errors++; $display("FAIL clrw_we got=%b exp=0", bus.mem_we); end
    @(negedge clk);
    bus.clear = 0;
    #1;
    checks += 3;
    if (bus.count !== 0) begin errors++; $display("FAIL clrw_count got=%0d exp=0", bus.count); end
    if (bus.req_ready !== 1) begin errors++; $display("FAIL clrw_ready got=%b exp=1", bus.req_ready); end
    if (bus.mem_we !== 0) begin errors++; $display("FAIL clrw_we_after got=%b exp=0", bus.mem_we); end
  endtask

  task automatic test_check_funct();
    logic [31:0] w;
    do_clear();
    send(2'b10, 4'h5, 5'd12, 5'd13, 5'd14, 12'd0, w);
    send(2'b10, 4'hF, 5'd1, 5'd1, 5'd1, 12'd0, w);
  endtask

  task automatic test_async_reset();
    logic [31:0] w;
    do_clear();
    send(2'b01, 4'h0, 5'd0, 5'd5, 5'd6, 12'h7FF, w);
    @(negedge clk);
    bus.req_kind = 2'b00; bus.req_rd = 5'd31; bus.req_rs1 = 5'd30; bus.req_imm = 12'hABC; bus.req_valid = 1;
    for (int t = 0; t < 20 && !bus.req_ready; t++) @(negedge clk);
    @(negedge clk);
    bus.req_valid = 0;
    checks++;
    if (bus.mem_we !== 1) begin errors++; $display("FAIL arst_pre_we got=%b exp=1", bus.mem_we); end
    #2 reset = 1;
    #1;
    checks += 6;
    if (bus.mem_we !== 0) begin errors++; $display("FAIL arst_we got=%b exp=0", bus.mem_we); end
    if (bus.mem_addr !== 0) begin errors++; $display("FAIL arst_addr got=%0d exp=0", bus.mem_addr); end
    if (bus.mem_wdata !== 0) begin errors++; $display("FAIL arst_wdata got=%h exp=0", bus.mem_wdata); end
    if (bus.count !== 0) begin errors++; $display("FAIL arst_count got=%0d exp=0", bus.count); end
    if (bus.req_ready !== 0) begin errors++; $display("FAIL arst_ready got=%b exp=0", bus.req_ready); end
    if (bus.full !== 0) begin errors++; $display("FAIL arst_full got=%b exp=0", bus.full); end
    @(negedge clk);
    reset = 0;
    m_ptr = 0; m_cnt = 0;
  endtask

  task automatic test_random();
    logic [31:0] w;
    for (int n = 0; n < 40; n++) begin
      if (m_cnt == CAP) do_clear();
      send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom),
           5'($urandom), 12'($urandom), w);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_clear_in_write();
    test_check_funct();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
